pulse_period_meter: RTL and testbench

//  - Consumer side of the ucounter impulse interface: takes a one-cycle tick train (e.g. ucounter o_impulse).
//  - Measures the number of i_clk cycles between two consecutive rising edges of i_pulse.
//  - Delivers the result over a valid/ready handshake.
//  - Sits in the timer datapath for self-check of prescaler output and for external-event period capture.

---
 rtl/pulse_period_meter.sv | 96 +++++++++
 tb/tb_pulse_period_meter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures i_clk cycles between consecutive rising edges of i_pulse
// and hands the result out over a valid/ready handshake, optionally re-arming.
module pulse_period_meter #(
   parameter int unsigned p_width    = 16,
   parameter bit          p_cont_def = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_pulse,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic               i_continuous,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [p_width-1:0] o_period,
   output logic               o_overflow,
   output logic               o_busy
);
   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
   state_t             state_q, state_d;
   logic               pulse_q, pulse_d;
   logic               cont_q, cont_d;
   logic               valid_q, valid_d;
   logic               overflow_q, overflow_d;
   logic               busy_q, busy_d;
   logic [p_width-1:0] count_q, count_d;
   logic [p_width-1:0] period_q, period_d;
   logic               edge_det;
   assign edge_det = i_pulse & ~pulse_q;
   always_comb begin
      state_d    = state_q;
      pulse_d    = i_pulse;
      cont_d     = cont_q;
      valid_d    = valid_q;
      overflow_d = overflow_q;
      count_d    = count_q;
      period_d   = period_q;
      if (i_abort) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (i_start) begin
               state_d    = ARMED;
               cont_d     = i_continuous;
               overflow_d = 1'b0;
            end
            ARMED: if (edge_det) begin
               state_d = MEASURE;
               count_d = p_width'(1);
            end
            MEASURE: begin
               if (edge_det || count_q == '1) begin
                  state_d    = DONE;
                  period_d   = count_q;
                  overflow_d = ~edge_det;
                  valid_d    = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
            DONE: if (valid_q && i_ready) begin
               // the edge seen in this cycle is deliberately not taken as a first edge
               state_d = cont_q ? ARMED : IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
      busy_d = (state_d == ARMED) || (state_d == MEASURE);
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         pulse_q    <= 1'b0;
         cont_q     <= p_cont_def;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         count_q    <= '0;
         period_q   <= '0;
      end else begin
         state_q    <= state_d;
         pulse_q    <= pulse_d;
         cont_q     <= cont_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
         period_q   <= period_d;
      end
   end
   assign o_valid    = valid_q;
   assign o_period   = period_q;
   assign o_overflow = overflow_q;
   assign o_busy     = busy_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed checks of pulse_period_meter (16-bit main instance, 4-bit overflow instance).
module tb_pulse_period_meter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pulse = 1'b0, start = 1'b0, abort = 1'b0, cont = 1'b0, ready = 1'b0;
   logic        valid, ovf, busy;
   logic [15:0] period;
   logic        pulse4 = 1'b0, start4 = 1'b0, ready4 = 1'b0;
   logic        valid4, ovf4, busy4;
   logic [3:0]  period4;
   int          n_cmp = 0, n_err = 0;
   logic        train_en = 1'b0;
   int          ph = 0, hi_len = 1;
   logic        stable;

   always #5 clk = ~clk;

   pulse_period_meter #(.p_width(16), .p_cont_def(1'b0)) dut (
      .i_clk(clk), .i_reset(rst), .i_pulse(pulse), .i_start(start), .i_abort(abort),
      .i_continuous(cont), .o_valid(valid), .i_ready(ready), .o_period(period),
      .o_overflow(ovf), .o_busy(busy));

   pulse_period_meter #(.p_width(4), .p_cont_def(1'b0)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_pulse(pulse4), .i_start(start4), .i_abort(1'b0),
      .i_continuous(1'b0), .o_valid(valid4), .i_ready(ready4), .o_period(period4),
      .o_overflow(ovf4), .o_busy(busy4));

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (train_en) begin
            ph = (ph == 9) ? 0 : ph + 1;
            pulse = (ph < hi_len);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic one_pulse();
      pulse = 1'b1;
      tick(1);
      pulse = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 50 && !valid; i++) tick(1);
      chk(tag, 32'(valid), 32'd1);
   endtask

   initial begin
      tick(3);
      chk("reset_valid", 32'(valid), 0);
      chk("reset_period", 32'(period), 0);
      chk("reset_ovf", 32'(ovf), 0);
      chk("reset_busy", 32'(busy), 0);
      rst = 1'b0;
      tick(2);
      chk("idle_busy", 32'(busy), 0);
      // 1) single shot, period 100
      start = 1'b1; tick(1); start = 1'b0;
      chk("t1_armed_busy", 32'(busy), 1);
      tick(4);
      one_pulse();
      tick(99);
      chk("t1_not_yet", 32'(valid), 0);
      one_pulse();
      chk("t1_valid", 32'(valid), 1);
      chk("t1_period", 32'(period), 100);
      chk("t1_ovf", 32'(ovf), 0);
      chk("t1_busy_done", 32'(busy), 0);
      ready = 1'b1; tick(1); ready = 1'b0;
      chk("t1_valid_clr", 32'(valid), 0);
      tick(20);
      chk("t1_idle_busy", 32'(busy), 0);
      // 2) overflow on the 4-bit instance
      start4 = 1'b1; tick(1); start4 = 1'b0;
      pulse4 = 1'b1; tick(1); pulse4 = 1'b0;
      tick(14);
      chk("t2_not_yet", 32'(valid4), 0);
      tick(1);
      chk("t2_valid", 32'(valid4), 1);
      chk("t2_period", 32'(period4), 32'hF);
      chk("t2_ovf", 32'(ovf4), 1);
      ready4 = 1'b1; tick(1); ready4 = 1'b0;
      chk("t2_valid_clr", 32'(valid4), 0);
      // 3) continuous, period-10 tick train with back-pressure
      cont = 1'b1; start = 1'b1; tick(1); start = 1'b0; cont = 1'b0;
      ph = 0; hi_len = 1; pulse = 1'b1; train_en = 1'b1;
      wait_valid("t3_valid1");
      chk("t3_period1", 32'(period), 10);
      stable = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         stable &= valid & (period == 16'd10);
      end
      chk("t3_hold", 32'(stable), 1);
      ready = 1'b1; tick(1); ready = 1'b0;
      chk("t3_valid_clr", 32'(valid), 0);
      chk("t3_rearmed", 32'(busy), 1);
      wait_valid("t3_valid2");
      chk("t3_period2", 32'(period), 10);
      abort = 1'b1; tick(1); abort = 1'b0;
      chk("t3_abort_busy", 32'(busy), 0);
      chk("t3_abort_valid", 32'(valid), 0);
      train_en = 1'b0; pulse = 1'b0;
      tick(3);
      // 4) wide pulses: edges only
      start = 1'b1; tick(1); start = 1'b0;
      ph = 0; hi_len = 5; pulse = 1'b1; train_en = 1'b1;
      wait_valid("t4_valid");
      chk("t4_period", 32'(period), 10);
      ready = 1'b1; tick(1); ready = 1'b0;
      chk("t4_idle", 32'(busy), 0);
      train_en = 1'b0; pulse = 1'b0;
      tick(12);
      chk("t4_no_rearm", 32'(valid), 0);
      // 5) abort mid-measure, fresh measurement, reset in DONE
      start = 1'b1; tick(1); start = 1'b0;
      one_pulse();
      tick(20);
      abort = 1'b1; tick(1); abort = 1'b0;
      chk("t5_abort_busy", 32'(busy), 0);
      tick(30);
      chk("t5_no_valid", 32'(valid), 0);
      chk("t5_period_kept", 32'(period), 10);
      start = 1'b1; tick(1); start = 1'b0;
      one_pulse();
      tick(6);
      one_pulse();
      chk("t5_valid", 32'(valid), 1);
      chk("t5_period", 32'(period), 7);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("t5_rst_valid", 32'(valid), 0);
      chk("t5_rst_period", 32'(period), 0);
      // 6) start ignored while measuring
      start = 1'b1; tick(1); start = 1'b0;
      one_pulse();
      tick(3);
      start = 1'b1; tick(1); start = 1'b0;
      tick(4);
      one_pulse();
      chk("t6_valid", 32'(valid), 1);
      chk("t6_period", 32'(period), 9);
      ready = 1'b1; tick(1); ready = 1'b0;
      // edge in the handshake cycle is not a first edge
      cont = 1'b1; start = 1'b1; tick(1); start = 1'b0; cont = 1'b0;
      one_pulse();
      tick(4);
      one_pulse();
      chk("t6c_period", 32'(period), 5);
      ready = 1'b1; pulse = 1'b1; tick(1); ready = 1'b0; pulse = 1'b0;
      chk("t6c_hs_valid", 32'(valid), 0);
      chk("t6c_armed", 32'(busy), 1);
      tick(3);
      one_pulse();
      chk("t6c_first_edge", 32'(valid), 0);
      tick(7);
      one_pulse();
      chk("t6c_valid", 32'(valid), 1);
      chk("t6c_period2", 32'(period), 8);
      abort = 1'b1; tick(1); abort = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
